fifo_push_ctrl: RTL and testbench
=================================

# fifo_push_ctrl

Write-side initiator for the 2-entry async FIFO's push/full port. It accepts a valid/ready data stream from local write-domain logic and buffers up to two words. It issues `push` strictly within the FIFO push protocol: push only when `full` was low on the previous cycle. It runs entirely in the write clock domain; a saturating stall counter gives visibility into FIFO back-pressure.

## Interface
Parameters:
- `DATA_W`, 8, width of the data word
- `STALL_W`, 16, width of the stall counter

Ports:
- `wclk` input 1: write-domain clock; all state updates on its rising edge
- `wreset` input 1: synchronous, active-high reset
- `in_valid` input 1: upstream word available
- `in_data` input DATA_W: upstream word
- `in_ready` output 1: block accepts the word this cycle
- `push` output 1: push one word into the FIFO this cycle
- `push_data` output DATA_W: word accompanying `push`
- `full` input 1: FIFO full flag, write-domain
- `stall_cnt` output STALL_W: saturating count of blocked cycles
- `busy` output 1: internal buffer non-empty

## Operation
- Internal 2-entry buffer: head/tail slots plus a `count` in 0..2.
- Accept: `in_valid && in_ready`; the word is written at the tail and `count` increments.
- `in_ready = (count != 2) && !wreset`. Combinational from the `count` flop only, with no path from `in_valid` or `full`.
- `full_q`: registered copy of `full`, reset to 1.
- `push = (count != 0) && !full_q && !full`. `push_data` = head word; on push the head is popped and `count` decrements.
- Simultaneous accept and push: `count` is unchanged, the head advances, and the new word lands behind the remaining entry. At `count==1` the pushed word leaves while the new word becomes head.
- Stall: a cycle with `count != 0 && !push` increments `stall_cnt`. It saturates at all-ones and never wraps.
- `busy = (count != 0)`.
- Protocol guarantee: `push` at cycle N implies `full` was 0 at N-1 and is 0 at N.

## Timing
- Reset values:
  - `count`=0, `full_q`=1, `stall_cnt`=0
  - outputs `push`=0, `in_ready`=0 while `wreset` is high, `busy`=0
  - `push_data` is don't-care when `push`=0
- Reset mid-operation discards buffered words, with no push in the reset cycle.
- First cycle after reset deassertion: `in_ready`=1 and `push`=0, because `full_q`=1. The earliest push is the second post-reset cycle, provided `full` was low in the first.
- Latency: a word accepted at edge N can push at N+1 at the earliest. `push` is never combinational from `in_valid`.
- Throughput: one word per cycle while `full` stays low.
- `full` rising at cycle N blocks push at N through `!full`, and at N+1 through `full_q`.
- `full` falling at cycle N: push resumes at N+1.
- `count==2`: `in_ready`=0. An upstream word is held by the upstream side and never dropped.

## Structure
- Shared package `fifo_pkg`: default `DATA_W`, `STALL_W`, `count_t` (2-bit, values 0..2).
- Sub-module `push_skid_buf`: 2-entry buffer with `count`, head/tail, and enq/deq handshakes.
- Top level adds `full_q`, push gating and the stall counter.

## Test plan
- Reset release with `full`=0 and `in_valid`=1, `in_data`=0xA5 at the first post-reset cycle: accepted at cycle 1, `push` with 0xA5 at cycle 2, `stall_cnt`=0.
- Stream 0x01..0x04 back-to-back with `full`=0: pushes on 4 consecutive cycles, order preserved, `in_ready` never drops.
- `full` forced high, 3 words offered: 2 accepted, `in_ready`=0 on the third, no `push`. After `full` drops at cycle N, pushes occur at N+1 and N+2, then the third word is accepted and pushed.
- `full` toggles high for one cycle between pushes: no `push` in either of the two cycles following the rise.
- Word blocked by `full` for 70000 cycles with `STALL_W`=16: `stall_cnt` holds at 0xFFFF.
- `wreset` asserted with `count`=2: `push`=0 and `busy`=0 next cycle. Post-reset `full_q`=1 delays the first push by one cycle.
- Continuous protocol check: `push |-> $past(full)==0 && full==0`, with `push_data` matching upstream order, across all scenarios.

Source files
------------

// File: rtl/fifo_push_ctrl_pkg.sv
// Shared types and defaults for the write-side push controller of the 2-entry async FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_STALL_W = 16;

    typedef logic [1:0] count_t;

    localparam count_t CNT_EMPTY = 2'd0;
    localparam count_t CNT_ONE   = 2'd1;
    localparam count_t CNT_FULL  = 2'd2;

    function automatic logic count_has_room(input count_t c);
        return (c != CNT_FULL);
    endfunction

endpackage

// File: rtl/fifo_push_ctrl_if.sv
// Upstream stream, FIFO push port and status bundle for fifo_push_ctrl.
interface fifo_push_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int STALL_W = DEF_STALL_W
);
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic               push;
    logic [DATA_W-1:0]  push_data;
    logic               full;
    logic [STALL_W-1:0] stall_cnt;
    logic               busy;

    modport slave (
        input  in_valid, in_data, full,
        output in_ready, push, push_data, stall_cnt, busy
    );

    modport master (
        output in_valid, in_data, full,
        input  in_ready, push, push_data, stall_cnt, busy
    );
endinterface

// File: rtl/push_skid_buf.sv
// Two-entry in-order word buffer with enqueue/dequeue handshakes; head is always the oldest word.
module push_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic [DATA_W-1:0] enq_data,
    output logic              enq_ready,
    input  logic              deq,
    output logic              deq_valid,
    output logic [DATA_W-1:0] deq_data,
    output count_t            count
);

    count_t            count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              acc_s;

    assign enq_ready = count_has_room(count_q) && !reset;
    assign acc_s     = enq_valid && enq_ready;
    assign deq_valid = (count_q != CNT_EMPTY);
    assign deq_data  = head_q;
    assign count     = count_q;

    // Next-state for occupancy and slots; deq is only ever raised while non-empty.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({acc_s, deq})
            2'b10: begin
                if (count_q == CNT_EMPTY) begin
                    head_d = enq_data;
                end else begin
                    tail_d = enq_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // With one entry the new word replaces the departing head directly.
                if (count_q == CNT_ONE) begin
                    head_d = enq_data;
                end else begin
                    head_d = tail_q;
                    tail_d = enq_data;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Buffer state registers; reset discards any held words.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/fifo_push_ctrl.sv
// Write-domain push initiator: buffers upstream words and pushes only when full was low last cycle and now.
module fifo_push_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int STALL_W = DEF_STALL_W
) (
    input  logic             wclk,
    input  logic             wreset,
    fifo_push_ctrl_if.slave  bus
);

    logic               full_q, full_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               push_s;
    logic               deq_valid_s;
    logic [DATA_W-1:0]  deq_data_s;
    count_t             count_s;

    push_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (wclk),
        .reset     (wreset),
        .enq_valid (bus.in_valid),
        .enq_data  (bus.in_data),
        .enq_ready (bus.in_ready),
        .deq       (push_s),
        .deq_valid (deq_valid_s),
        .deq_data  (deq_data_s),
        .count     (count_s)
    );

    // Push gating and saturating back-pressure counter.
    always_comb begin
        full_d = bus.full;
        push_s = deq_valid_s && !full_q && !bus.full && !wreset;
        if (deq_valid_s && !push_s && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // full_q resets high so the first post-reset cycle never pushes.
    always_ff @(posedge wclk) begin
        if (wreset) begin
            full_q  <= 1'b1;
            stall_q <= '0;
        end else begin
            full_q  <= full_d;
            stall_q <= stall_d;
        end
    end

    assign bus.push      = push_s;
    assign bus.push_data = deq_data_s;
    assign bus.stall_cnt = stall_q;
    assign bus.busy      = (count_s != CNT_EMPTY);

endmodule

// File: tb/tb_fifo_push_ctrl.sv
// Directed and random stimulus for fifo_push_ctrl, checked against a queue-based reference model.
module tb_fifo_push_ctrl;

    logic wclk;
    logic wreset;

    fifo_push_ctrl_if #(.DATA_W(8), .STALL_W(16)) bus ();

    fifo_push_ctrl #(.DATA_W(8), .STALL_W(16)) dut (
        .wclk   (wclk),
        .wreset (wreset),
        .bus    (bus)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic       m_full_prev = 1'b1;
    int         m_stall     = 0;
    logic       raw_full_prev = 1'b1;
    logic       last_acc, last_push, dut_push, dut_rdy;
    logic [7:0] dut_pd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model on the edge.
    task automatic step();
        logic m_rdy, m_push;
        #2;
        m_rdy  = (mq.size() < 2) && !wreset;
        m_push = (mq.size() != 0) && !m_full_prev && !bus.full && !wreset;
        dut_push = bus.push;
        dut_rdy  = bus.in_ready;
        dut_pd   = bus.push_data;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
        chk("push", {31'd0, bus.push}, {31'd0, m_push});
        chk("busy", {31'd0, bus.busy}, {31'd0, (mq.size() != 0)});
        chk("stall_cnt", {16'd0, bus.stall_cnt}, m_stall);
        if (m_push) chk("push_data", {24'd0, bus.push_data}, {24'd0, mq[0]});
        if (bus.push) chk("protocol", {30'd0, raw_full_prev, bus.full}, 32'd0);
        last_acc  = bus.in_valid && m_rdy;
        last_push = m_push;
        @(posedge wclk);
        if (wreset) begin
            mq.delete();
            m_full_prev = 1'b1;
            m_stall     = 0;
        end else begin
            if (mq.size() != 0 && !m_push && m_stall < 65535) m_stall++;
            if (m_push) void'(mq.pop_front());
            if (last_acc) mq.push_back(bus.in_data);
            m_full_prev = bus.full;
        end
        raw_full_prev = bus.full;
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.full     = f;
        step();
    endtask

    initial begin
        int guard;
        int pushes;
        logic pend;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        bus.full     = 1'b0;
        wreset       = 1'b1;
        @(posedge wclk);
        #1;

        // Reset state, then first word through with full low.
        step();
        step();
        chk("rst_ready", {31'd0, dut_rdy}, 32'd0);
        wreset = 1'b0;
        drive(1'b1, 8'hA5, 1'b0);
        chk("c1_accept", {31'd0, last_acc}, 32'd1);
        chk("c1_nopush", {31'd0, dut_push}, 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        chk("c2_push", {31'd0, dut_push}, 32'd1);
        chk("c2_data", {24'd0, dut_pd}, 32'hA5);
        chk("c2_stall", {16'd0, bus.stall_cnt}, 32'd0);

        // Back-to-back stream.
        pushes = 0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            chk("stream_ready", {31'd0, dut_rdy}, 32'd1);
            pushes += int'(dut_push);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            pushes += int'(dut_push);
        end
        chk("stream_pushes", pushes, 32'd4);

        // Full held high: two words fit, third is refused until drain.
        drive(1'b1, 8'h10, 1'b1);
        drive(1'b1, 8'h11, 1'b1);
        drive(1'b1, 8'h12, 1'b1);
        chk("full_third_rdy", {31'd0, dut_rdy}, 32'd0);
        drive(1'b1, 8'h12, 1'b1);
        chk("full_nopush", {31'd0, dut_push}, 32'd0);
        drive(1'b1, 8'h12, 1'b0);
        chk("drop_n_nopush", {31'd0, dut_push}, 32'd0);
        drive(1'b1, 8'h12, 1'b0);
        chk("drop_n1_data", {23'd0, dut_push, dut_pd}, 32'h110);
        drive(1'b1, 8'h12, 1'b0);
        chk("drop_n2_data", {23'd0, dut_push, dut_pd}, 32'h111);
        chk("drop_n2_acc", {31'd0, last_acc}, 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        chk("drop_n3_data", {23'd0, dut_push, dut_pd}, 32'h112);

        // One-cycle full pulse between pushes.
        drive(1'b1, 8'h20, 1'b0);
        drive(1'b1, 8'h21, 1'b0);
        drive(1'b1, 8'h22, 1'b1);
        chk("pulse_rise", {31'd0, dut_push}, 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        chk("pulse_after", {31'd0, dut_push}, 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0);

        // Long block: stall counter saturates.
        drive(1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 70000; i++) drive(1'b0, 8'h00, 1'b1);
        chk("stall_sat", {16'd0, bus.stall_cnt}, 32'h0000FFFF);

        // Reset with two held words.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h6B;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!last_acc && guard < 10);
        chk("hold_acc", {31'd0, last_acc}, 32'd1);
        chk("busy_two", {31'd0, bus.busy}, 32'd1);
        bus.full = 1'b0;
        wreset   = 1'b1;
        step();
        chk("rst_mid_nopush", {31'd0, dut_push}, 32'd0);
        wreset = 1'b0;
        drive(1'b1, 8'hC3, 1'b0);
        chk("post_rst_busy", {31'd0, (mq.size() == 1)}, 32'd1);
        chk("post_rst_nopush", {31'd0, dut_push}, 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        chk("post_rst_push", {23'd0, dut_push, dut_pd}, 32'h1C3);

        // Random traffic with holding upstream and rare resets.
        pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            wreset = ($urandom_range(0, 199) == 0);
            if (!pend) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                bus.in_data  = 8'($urandom);
            end
            bus.full = ($urandom_range(0, 3) == 0);
            step();
            pend = bus.in_valid && !last_acc && !wreset;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
